// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared definitions for the MIPS decode->E/M/W control pipeline.
//   - Stage indices STG_E / STG_M / STG_W.
//   - Control bundle layout (bit positions plus a packed struct view).
//   - Default per-stage keep masks. Each mask keeps only the bits that stage or a
//     later stage still consumes, so unused flops are pruned in synthesis.
package ctrl_pipe_pkg;

  localparam int CTRL_W = 32;

  // Stage indices
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // Bundle bit positions
  localparam int MEMTOREG    = 0;
  localparam int MEMWRITE    = 1;
  localparam int REGWRITE    = 2;
  localparam int CP0WE       = 3;
  localparam int MEMREAD     = 4;
  localparam int ALUCTRL_LSB = 5;   // ALUCTRL[4:0] at [9:5]
  localparam int SA_LSB      = 10;  // SA[4:0]      at [14:10]
  localparam int BRANCH      = 15;
  localparam int JUMP        = 16;

  // Struct view of the same layout. Field order is MSB first.
  typedef struct packed {
    logic [14:0] rsvd;
    logic        jump;
    logic        branch;
    logic [4:0]  sa;
    logic [4:0]  aluCtrl;
    logic        memRead;
    logic        cp0We;
    logic        regWrite;
    logic        memWrite;
    logic        memToReg;
  } ctrlBundle_t;

  // E consumes everything. M needs only the memory and writeback bits.
  // W needs only the writeback bits.
  localparam logic [CTRL_W-1:0] KEEP_E = '1;
  localparam logic [CTRL_W-1:0] KEEP_M = CTRL_W'((1 << MEMTOREG) | (1 << MEMWRITE) |
                                                 (1 << REGWRITE) | (1 << CP0WE) |
                                                 (1 << MEMREAD));
  localparam logic [CTRL_W-1:0] KEEP_W = CTRL_W'((1 << MEMTOREG) | (1 << REGWRITE) |
                                                 (1 << CP0WE));

  // Ready-made KEEP_MASK for the three-stage MIPS pipeline. Stage 0 is the LSB slice.
  localparam logic [3*CTRL_W-1:0] MIPS_KEEP_MASK = {KEEP_W, KEEP_M, KEEP_E};

  // Saturating increment used by the optional perf counters.
  function automatic logic [31:0] satInc(input logic [31:0] v, input logic [31:0] maxV);
    return (v == maxV) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one control-bundle register stage.
//   Priority on each edge: flush > stall (hold) > auto-bubble (source stalled) > advance.
//   On advance the bundle is ANDed with KEEP, so masked bits are always 0 in the state.
//   Optional perf counters are built only when CTRL_PIPE_PERF_EN is defined.
// Ports:
//   clk, rst           clock, async active-low reset
//   srcCtrl/srcValid   upstream bundle and valid
//   srcStall           upstream is stalled this cycle (its bundle is not moving)
//   stall, flush       this stage's controls
//   ctrl, valid        registered bundle and valid
//   perfBubble/Flush   saturating event counts (0 when perf is disabled)
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int             W     = 32,
  parameter int             CNT_W = 16,
  parameter logic [W-1:0]   KEEP  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     srcCtrl,
  input  logic             srcValid,
  input  logic             srcStall,
  input  logic             stall,
  input  logic             flush,
  output logic [W-1:0]     ctrl,
  output logic             valid,
  output logic [CNT_W-1:0] perfBubble,
  output logic [CNT_W-1:0] perfFlush
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      ctrl  <= '0;
      valid <= 1'b0;
    end else if (!stall) begin
      if (srcStall) begin
        // The upstream bundle stays upstream. Load a bubble so it is not duplicated.
        ctrl  <= '0;
        valid <= 1'b0;
      end else begin
        // An invalid source still carries its ctrl bits through (masked).
        ctrl  <= srcCtrl & KEEP;
        valid <= srcValid;
      end
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic loadBubble;
  assign loadBubble = srcStall & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfBubble <= '0;
      perfFlush  <= '0;
    end else begin
      if (loadBubble && perfBubble != CNT_MAX) perfBubble <= perfBubble + 1'b1;
      if (flush && perfFlush != CNT_MAX)       perfFlush  <= perfFlush + 1'b1;
    end
  end
`else
  assign perfBubble = '0;
  assign perfFlush  = '0;
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: parametrised control-bundle pipeline (decode -> NSTG stages, default E/M/W).
//   Each stage has its own stall, flush and valid. Bubbles are inserted where an
//   upstream stage holds, and per-stage KEEP_MASK slices prune unused bits.
//   stall_err goes sticky-high on any non-monotonic stall, meaning stall[i] is set
//   without in_hold and every stall[j<i] also set.
// Optional feature macro: CTRL_PIPE_PERF_EN enables per-stage bubble/flush counters.
//   Without it, the perf_* ports read 0 and no counter flops exist.
// Ports:
//   clk, rst (async, active-low)
//   in_ctrl[W], in_valid, in_hold     decode-stage bundle, valid, stalled
//   stall[NSTG], flush[NSTG]          per-stage controls
//   out_ctrl[NSTG*W], out_valid[NSTG] stage i at slice [i*W +: W]
//   stall_err                         sticky stall-ordering error
//   perf_bubble, perf_flush           [NSTG*CNT_W] per-stage counters
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                W         = 32,
  parameter int                NSTG      = 3,
  parameter logic [NSTG*W-1:0] KEEP_MASK = {NSTG*W{1'b1}},
  parameter int                CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          in_ctrl,
  input  logic                  in_valid,
  input  logic                  in_hold,
  input  logic [NSTG-1:0]       stall,
  input  logic [NSTG-1:0]       flush,
  output logic [NSTG*W-1:0]     out_ctrl,
  output logic [NSTG-1:0]       out_valid,
  output logic                  stall_err,
  output logic [NSTG*CNT_W-1:0] perf_bubble,
  output logic [NSTG*CNT_W-1:0] perf_flush
);

  logic [NSTG-1:0][W-1:0]     stCtrl;
  logic [NSTG-1:0]            stValid;
  logic [NSTG-1:0][W-1:0]     srcCtrl;
  logic [NSTG-1:0]            srcValid;
  logic [NSTG-1:0]            srcStall;
  logic [NSTG-1:0][CNT_W-1:0] pBub;
  logic [NSTG-1:0][CNT_W-1:0] pFl;

  for (genvar i = 0; i < NSTG; i++) begin : gStage
    if (i == 0) begin : gHead
      assign srcCtrl[i]  = in_ctrl;
      assign srcValid[i] = in_valid;
      assign srcStall[i] = in_hold;
    end else begin : gBody
      assign srcCtrl[i]  = stCtrl[i-1];
      assign srcValid[i] = stValid[i-1];
      assign srcStall[i] = stall[i-1];
    end

    ctrl_pipe_stage #(
      .W     (W),
      .CNT_W (CNT_W),
      .KEEP  (KEEP_MASK[i*W +: W])
    ) uStage (
      .clk        (clk),
      .rst        (rst),
      .srcCtrl    (srcCtrl[i]),
      .srcValid   (srcValid[i]),
      .srcStall   (srcStall[i]),
      .stall      (stall[i]),
      .flush      (flush[i]),
      .ctrl       (stCtrl[i]),
      .valid      (stValid[i]),
      .perfBubble (pBub[i]),
      .perfFlush  (pFl[i])
    );
  end

  assign out_ctrl    = stCtrl;
  assign out_valid   = stValid;
  assign perf_bubble = pBub;
  assign perf_flush  = pFl;

  // Walk from decode downstream. A stage may stall only when every stage upstream
  // of it, including decode, is also stalled.
  logic stallBad;
  logic upStalled;
  always_comb begin
    stallBad  = 1'b0;
    upStalled = in_hold;
    for (int i = 0; i < NSTG; i++) begin
      if (stall[i] && !upStalled) stallBad = 1'b1;
      upStalled = upStalled & stall[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          stall_err <= 1'b0;
    else if (stallBad) stall_err <= 1'b1;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed stimulus plus a per-cycle compare against a stage-array model.
module tb_ctrl_pipe;
  localparam int W     = 32;
  localparam int NSTG  = 3;
  localparam int CNT_W = 4;
  localparam logic [NSTG*W-1:0] KEEP = {32'h0000_00FF, 32'h0FFF_FFFF, 32'hFFFF_FFFF};

  logic                  clk = 1'b0;
  logic                  rst;
  logic [W-1:0]          in_ctrl;
  logic                  in_valid, in_hold;
  logic [NSTG-1:0]       stall, flush;
  logic [NSTG*W-1:0]     out_ctrl;
  logic [NSTG-1:0]       out_valid;
  logic                  stall_err;
  logic [NSTG*CNT_W-1:0] perf_bubble, perf_flush;

  int nVec = 0;
  int nErr = 0;

  ctrl_pipe #(.W(W), .NSTG(NSTG), .KEEP_MASK(KEEP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_hold(in_hold),
    .stall(stall), .flush(flush), .out_ctrl(out_ctrl), .out_valid(out_valid),
    .stall_err(stall_err), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // ---------------- model: one entry per stage, spec rules applied directly ----------------
  logic [W-1:0] mCtrl [NSTG];
  logic         mVal  [NSTG];
  int           mPB   [NSTG];
  int           mPF   [NSTG];
  logic         mErr;

  function automatic logic [W-1:0] mask(input int i);
    return KEEP[i*W +: W];
  endfunction
  function automatic logic [W-1:0] srcC(input int i);
    return (i == 0) ? in_ctrl : mCtrl[i-1];
  endfunction
  function automatic logic srcV(input int i);
    return (i == 0) ? in_valid : mVal[i-1];
  endfunction
  function automatic logic srcS(input int i);
    return (i == 0) ? in_hold : stall[i-1];
  endfunction
  function automatic logic violation();
    for (int i = 0; i < NSTG; i++) begin
      if (stall[i]) begin
        if (!in_hold) return 1'b1;
        for (int j = 0; j < i; j++) if (!stall[j]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction
  function automatic logic [CNT_W-1:0] expCnt(input int c);
`ifdef CTRL_PIPE_PERF_EN
    return (c > (1 << CNT_W) - 1) ? CNT_W'((1 << CNT_W) - 1) : CNT_W'(c);
`else
    return CNT_W'(c & 0);
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTG; i++) begin
        mCtrl[i] <= '0; mVal[i] <= 1'b0; mPB[i] <= 0; mPF[i] <= 0;
      end
      mErr <= 1'b0;
    end else begin
      for (int i = 0; i < NSTG; i++) begin
        if (flush[i]) begin
          mCtrl[i] <= '0; mVal[i] <= 1'b0; mPF[i] <= mPF[i] + 1;
        end else if (stall[i]) begin
          mCtrl[i] <= mCtrl[i]; mVal[i] <= mVal[i];
        end else if (srcS(i)) begin
          mCtrl[i] <= '0; mVal[i] <= 1'b0; mPB[i] <= mPB[i] + 1;
        end else begin
          mCtrl[i] <= srcC(i) & mask(i); mVal[i] <= srcV(i);
        end
      end
      if (violation()) mErr <= 1'b1;
    end
  end

  // Compare every output on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NSTG; i++) begin
      chk($sformatf("cmp ctrl[%0d]", i), 128'(out_ctrl[i*W +: W]), 128'(mCtrl[i]));
      chk($sformatf("cmp valid[%0d]", i), 128'(out_valid[i]), 128'(mVal[i]));
      chk($sformatf("cmp pbub[%0d]", i), 128'(perf_bubble[i*CNT_W +: CNT_W]), 128'(expCnt(mPB[i])));
      chk($sformatf("cmp pfl[%0d]", i), 128'(perf_flush[i*CNT_W +: CNT_W]), 128'(expCnt(mPF[i])));
    end
    chk("cmp stall_err", 128'(stall_err), 128'(mErr));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic drive(input logic [W-1:0] c, input logic v, input logic h,
                       input logic [NSTG-1:0] s, input logic [NSTG-1:0] f);
    in_ctrl = c; in_valid = v; in_hold = h; stall = s; flush = f;
  endtask

  logic [CNT_W-1:0] satExp;

  initial begin
    rst = 1'b0;
    drive('0, 1'b0, 1'b0, '0, '0);
    #2;
    chk("reset out_ctrl", 128'(out_ctrl), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset stall_err", 128'(stall_err), 128'(0));
    #10 rst = 1'b1;
    step(); step();

    // Free flow. Stage 1 mask drops the top nibble, stage 2 keeps the low byte only.
    drive(32'hA5A5_0001, 1'b1, 1'b0, '0, '0); step();
    chk("flow s0 edge1", 128'(out_ctrl[31:0]), 128'(32'hA5A5_0001));
    chk("flow v0 edge1", 128'(out_valid[0]), 128'(1));
    drive('0, 1'b0, 1'b0, '0, '0); step();
    chk("flow s1 edge2", 128'(out_ctrl[63:32]), 128'(32'h05A5_0001));
    step();
    chk("flow s2 edge3", 128'(out_ctrl[95:64]), 128'(32'h0000_0001));
    chk("flow v2 edge3", 128'(out_valid[2]), 128'(1));

    // Load-use stall: stage 0 holds X, stage 1 bubbles, stage 2 advances.
    drive(32'h0000_00AA, 1'b1, 1'b0, '0, '0); step();
    drive(32'h1234_5678, 1'b1, 1'b0, '0, '0); step();
    drive(32'hDEAD_BEEF, 1'b1, 1'b1, 3'b001, '0); step();
    chk("stall s0 hold", 128'(out_ctrl[31:0]), 128'(32'h1234_5678));
    chk("stall v0 hold", 128'(out_valid[0]), 128'(1));
    chk("stall s1 bubble", 128'({out_valid[1], out_ctrl[63:32]}), 128'(0));
    chk("stall s2 adv", 128'({out_valid[2], out_ctrl[95:64]}), 128'({1'b1, 32'h0000_00AA}));
`ifdef CTRL_PIPE_PERF_EN
    chk("stall pbub1", 128'(perf_bubble[7:4]), 128'(1));
`else
    chk("stall pbub1", 128'(perf_bubble[7:4]), 128'(0));
`endif

    // Branch flush with stall[0]: flush wins, and this stall pattern is legal.
    drive(32'hDEAD_BEEF, 1'b1, 1'b1, 3'b001, 3'b001); step();
    chk("flush s0", 128'({out_valid[0], out_ctrl[31:0]}), 128'(0));
    chk("flush err", 128'(stall_err), 128'(0));
`ifdef CTRL_PIPE_PERF_EN
    chk("flush pfl0", 128'(perf_flush[3:0]), 128'(1));
`else
    chk("flush pfl0", 128'(perf_flush[3:0]), 128'(0));
`endif

    // An invalid source with nonzero ctrl carries its ctrl bits, masked, with valid=0.
    drive(32'hFFFF_FFFF, 1'b0, 1'b0, '0, '0); step();
    chk("inv s0", 128'({out_valid[0], out_ctrl[31:0]}), 128'({1'b0, 32'hFFFF_FFFF}));
    drive('0, 1'b0, 1'b0, '0, '0); step(); step();
    chk("inv s2 masked", 128'({out_valid[2], out_ctrl[95:64]}), 128'({1'b0, 32'h0000_00FF}));

    // Flush every stage at once.
    drive(32'h0000_1111, 1'b1, 1'b0, '0, '0); step();
    drive(32'h0000_2222, 1'b1, 1'b0, '0, '0); step();
    drive(32'h0000_3333, 1'b1, 1'b0, '0, 3'b111); step();
    chk("allflush valid", 128'(out_valid), 128'(0));
    chk("allflush ctrl", 128'(out_ctrl), 128'(0));
    chk("allflush err", 128'(stall_err), 128'(0));

    // Hold flush[2] for 20 cycles so the 4-bit counter saturates.
    drive(32'h0000_4444, 1'b1, 1'b0, '0, 3'b100);
    repeat (20) step();
`ifdef CTRL_PIPE_PERF_EN
    satExp = 4'hF;
`else
    satExp = 4'h0;
`endif
    chk("sat pfl2", 128'(perf_flush[11:8]), 128'(satExp));

    // Illegal stall: stage 1 stalls while decode and stage 0 run.
    drive(32'h0000_5555, 1'b1, 1'b0, 3'b010, '0); step();
    chk("illegal err set", 128'(stall_err), 128'(1));
    drive('0, 1'b0, 1'b0, '0, '0); step(); step(); step();
    chk("illegal err sticky", 128'(stall_err), 128'(1));

    // Mid-stream asynchronous reset, asserted between edges.
    drive(32'h0000_7777, 1'b1, 1'b0, '0, '0); step(); step();
    #2 rst = 1'b0;
    #1;
    chk("async rst ctrl", 128'(out_ctrl), 128'(0));
    chk("async rst valid", 128'(out_valid), 128'(0));
    chk("async rst err", 128'(stall_err), 128'(0));
    chk("async rst perf", 128'({perf_bubble, perf_flush}), 128'(0));
    #4 rst = 1'b1;
    drive(32'h0000_8888, 1'b1, 1'b0, '0, '0); step();
    drive('0, 1'b0, 1'b0, '0, '0); step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
